// File: rtl/sap_program_sequencer.sv
// SAP program sequencer: streams opcode/operand bytes into program RAM,
// then owns CPU reset and controller clock enable for run/step/halt.
module sap_program_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  input  logic                  i_start_load,
  input  logic                  i_run_request,
  input  logic                  i_step_request,
  input  logic                  i_halt,
  output logic                  o_program_mode,
  output logic [ADDR_WIDTH-1:0] o_program_address,
  output logic [15:0]           o_program_data,
  output logic                  o_program_write,
  output logic                  o_cpu_reset,
  output logic                  o_cpu_clock_enable,
  output logic                  o_load_done,
  output logic [3:0]            o_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD_HI = 4'd1,
    S_LOAD_LO = 4'd2,
    S_WRITE   = 4'd3,
    S_RELEASE = 4'd4,
    S_READY   = 4'd5,
    S_RUN     = 4'd6,
    S_PAUSED  = 4'd7,
    S_HALTED  = 4'd8
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  done_q, done_d;
  logic [2:0]            req_hist_q;
  logic                  mode_q, mode_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic                  en_q, en_d;
  logic                  start_ev, run_ev, step_ev;
  logic                  pulse;

  assign start_ev = i_start_load   & ~req_hist_q[2];
  assign run_ev   = i_run_request  & ~req_hist_q[1];
  assign step_ev  = i_step_request & ~req_hist_q[0];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      req_hist_q <= '0;
      mode_q     <= 1'b1;
      cpu_rst_q  <= 1'b1;
      write_q    <= 1'b0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      req_hist_q <= {i_start_load, i_run_request, i_step_request};
      mode_q     <= mode_d;
      cpu_rst_q  <= cpu_rst_d;
      write_q    <= write_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = done_q;
    pulse   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d = S_LOAD_HI;
          addr_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_LOAD_HI: begin
        if (i_byte_valid && ready_q) begin
          data_d[15:8] = i_byte;
          state_d      = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        if (i_byte_valid && ready_q) begin
          data_d[7:0] = i_byte;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: state_d = S_RELEASE;
      S_RELEASE: begin
        if (addr_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = S_READY;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_LOAD_HI;
        end
      end
      S_READY: begin
        if (start_ev) begin
          state_d = S_LOAD_HI;
          addr_d  = '0;
          done_d  = 1'b0;
        end else if (run_ev) begin
          state_d = S_RUN;
        end else if (step_ev) begin
          state_d = S_PAUSED;
          pulse   = 1'b1;
        end
      end
      S_RUN: begin
        if (i_halt) state_d = S_HALTED;
        else if (step_ev) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        // halt outranks run and step so a halted CPU never gets a clock
        if (start_ev) begin
          state_d = S_LOAD_HI;
          addr_d  = '0;
          done_d  = 1'b0;
        end else if (i_halt) begin
          state_d = S_HALTED;
        end else if (run_ev) begin
          state_d = S_RUN;
        end else if (step_ev) begin
          pulse = 1'b1;
        end
      end
      S_HALTED: begin
        if (start_ev) begin
          state_d = S_LOAD_HI;
          addr_d  = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are computed from the next state so every port is a flop
  always_comb begin
    mode_d    = 1'b1;
    cpu_rst_d = 1'b1;
    write_d   = 1'b0;
    ready_d   = 1'b0;
    en_d      = pulse;
    unique case (state_d)
      S_LOAD_HI, S_LOAD_LO: ready_d = 1'b1;
      S_WRITE: write_d = 1'b1;
      S_RUN: begin
        mode_d    = 1'b0;
        cpu_rst_d = 1'b0;
        en_d      = 1'b1;
      end
      S_PAUSED, S_HALTED: begin
        mode_d    = 1'b0;
        cpu_rst_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_byte_ready       = ready_q;
  assign o_program_mode     = mode_q;
  assign o_program_address  = addr_q;
  assign o_program_data     = data_q;
  assign o_program_write    = write_q;
  assign o_cpu_reset        = cpu_rst_q;
  assign o_cpu_clock_enable = en_q;
  assign o_load_done        = done_q;
  assign o_state            = state_q;

endmodule
